dmem_responder: RTL

- Memory-side responder for the MEM-stage data port.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a parameterised number of wait states, performs a byte-enabled access to an internal word array, then returns a one-cycle response.
- Sits between the MEM stage (initiator) and the data storage; replaces zero-latency data memory so stall logic can be exercised.

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_word_array.sv | 33 +++
 rtl/dmem_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_responder_pkg;

  // Responder FSM states; ST_CLEAR is only reachable when DMEM_CLEAR_EN is defined
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int LANE_W    = 8;            // bits per byte lane
  localparam int NUM_LANES = 4;            // byte lanes per 32-bit word
  localparam int IDX_SHIFT = 2;            // byte address -> word index shift
  localparam logic ERR_ACCESS = 1'b1;      // value of resp_err for a rejected access

  // An access is rejected when the word index falls off the array or no lane is enabled.
  function automatic logic acc_err(input logic [31:0] addr,
                                   input logic [NUM_LANES-1:0] be,
                                   input int unsigned depth);
    logic [31:0] w_idx;
    w_idx = addr >> IDX_SHIFT;
    return (w_idx >= depth) || (be == '0);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port word array, 4 byte-write enables, synchronous write / combinational read.
// Latency: write lands on the clock edge; read data follows the index in the same cycle.
// Backpressure: none; the caller serialises accesses.
module dmem_word_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [NUM_LANES-1:0] i_be,
  input  logic [AW-1:0]        i_idx,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write: only enabled lanes change, the rest of the word is preserved
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one request at a time, WAIT_CYCLES wait states, byte-enabled access.
// Latency: response strobe in the (WAIT_CYCLES+1)th cycle after the accept cycle.
// Backpressure: req_ready only in IDLE; busy covers WAIT/RESP (and the DMEM_CLEAR_EN sweep).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
`ifdef DMEM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  // Captured request
  logic             r_we;
  logic [3:0]       r_be;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  // Response registers
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_access;
  logic             w_acc_we;
  logic [3:0]       w_acc_be;
  logic [31:0]      w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic             w_acc_err;

  logic             w_arr_we;
  logic [3:0]       w_arr_be;
  logic [AW-1:0]    w_arr_idx;
  logic [31:0]      w_arr_wdata;
  logic [31:0]      w_arr_rdata;

`ifdef DMEM_CLEAR_EN
  logic [AW-1:0]    r_clr_idx;
`endif

  assign w_accept = req_valid && req_ready;

  // State register; reset lands in IDLE, or in the clear sweep when it is built in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, access strobe and the externally visible handshake/response outputs
  always_comb begin
    w_next     = r_state;
    w_access   = 1'b0;
    req_ready  = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated by reset so the port reads not-ready while reset is held
        req_ready = reset;
        if (w_accept) begin
          if (ZERO_WAIT) begin
            w_next   = ST_RESP;
            w_access = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        busy = reset;
        if (r_cnt == '0) begin
          w_next   = ST_RESP;
          w_access = 1'b1;
        end
      end
      ST_RESP: begin
        busy       = reset;
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_err   = r_err;
        w_next     = ST_IDLE;
      end
      ST_CLEAR: begin
        busy = reset;
`ifdef DMEM_CLEAR_EN
        if (r_clr_idx == AW'(DEPTH_WORDS - 1)) begin
          w_next = ST_IDLE;
        end
`else
        w_next = ST_IDLE;
`endif
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // With no wait states the access happens on the accept edge, so it uses the live request
  always_comb begin
    w_acc_we    = ZERO_WAIT ? req_we    : r_we;
    w_acc_be    = ZERO_WAIT ? req_be    : r_be;
    w_acc_addr  = ZERO_WAIT ? req_addr  : r_addr;
    w_acc_wdata = ZERO_WAIT ? req_wdata : r_wdata;
    w_acc_err   = acc_err(w_acc_addr, w_acc_be, DEPTH_WORDS);
  end

  // Array port steering: normal accesses, or the zero-fill sweep while clearing
  always_comb begin
    w_arr_we    = w_access && w_acc_we && !w_acc_err;
    w_arr_be    = w_acc_be;
    w_arr_idx   = w_acc_addr[IDX_SHIFT +: AW];
    w_arr_wdata = w_acc_wdata;
`ifdef DMEM_CLEAR_EN
    if (r_state == ST_CLEAR) begin
      w_arr_we    = reset;
      w_arr_be    = '1;
      w_arr_idx   = r_clr_idx;
      w_arr_wdata = '0;
    end
`endif
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_we    <= req_we;
        r_be    <= req_be;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        r_err   <= w_acc_err ? ERR_ACCESS : 1'b0;
        r_rdata <= (w_acc_we || w_acc_err) ? 32'h0 : w_arr_rdata;
      end
    end
  end

`ifdef DMEM_CLEAR_EN
  // Sweep pointer; any reset restarts the clear from word 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_idx <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end
`endif

  dmem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_be    (w_arr_be),
    .i_idx   (w_arr_idx),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

endmodule
